my_nios_key_debounce: RTL and testbench

Conditions one raw push-button input from the board for the PIO interrupt stage. Synchronises the asynchronous pin and removes contact bounce with a counter-qualified state machine. Emits a clean level (`key_level`), which drives the PIO `in_port`, plus single-cycle press/release strobes and a saturating press counter for firmware diagnostics. Sits between the top-level key pin and the PIO, inside the `my_nios` system clock domain.

---
 rtl/my_nios_pkg.sv | 17 +
 rtl/my_nios_sync2.sv | 25 ++
 rtl/my_nios_key_debounce.sv | 117 +++++++++++
 tb/tb_my_nios_key_debounce.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/my_nios_pkg.sv
// Shared definitions for the my_nios board-input conditioning blocks:
// debounce FSM state encoding and the debounce counter width helper.
package my_nios_pkg;

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_WAIT_DN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_WAIT_UP = 2'd3
    } db_state_t;

    // Wide enough to hold DEBOUNCE_CYCLES itself, so the qualification count never wraps.
    function automatic int DB_CNT_W(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/my_nios_sync2.sv
// Generic two-flop synchroniser for asynchronous board inputs; the reset value
// lets each input start in its own idle level.
module my_nios_sync2 #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/my_nios_key_debounce.sv
// Push-button conditioner for the PIO: polarity normalisation, synchronisation,
// counter-qualified debounce FSM, press/release strobes and a saturating press counter.
module my_nios_key_debounce
    import my_nios_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_raw,
    input  logic                   count_clr,
    output logic                   key_level,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic [COUNT_WIDTH-1:0] press_count
);

    localparam int                   CNT_W     = DB_CNT_W(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic             p;
    logic             s;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             press_accept;

    assign p = key_raw ^ ACTIVE_LOW;

    // Both flops reset to "released" so a held key must requalify after reset.
    my_nios_sync2 #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (p),
        .q     (s)
    );

    assign press_accept = (state == ST_WAIT_DN) && s && (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_UP;
            cnt           <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                ST_UP: begin
                    if (s) begin
                        state <= ST_WAIT_DN;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_WAIT_DN: begin
                    if (!s) begin
                        state <= ST_UP;
                        cnt   <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state       <= ST_DOWN;
                        cnt         <= '0;
                        key_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (!s) begin
                        state <= ST_WAIT_UP;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_WAIT_UP: begin
                    if (s) begin
                        state <= ST_DOWN;
                        cnt   <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state         <= ST_UP;
                        cnt           <= '0;
                        key_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_UP;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Clear wins over a coincident press, so firmware never sees a stale count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_count <= '0;
        end else if (count_clr) begin
            press_count <= '0;
        end else if (press_accept && (press_count != COUNT_MAX)) begin
            press_count <= press_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_my_nios_key_debounce.sv
// Bench for my_nios_key_debounce: directed scenarios plus random key activity on an
// active-low and an active-high build, checked against a run-length reference model.
module tb_my_nios_key_debounce;

    localparam int DB   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk;
    logic          reset;
    logic          key0, key1;
    logic          clr0, clr1;
    logic          level0, level1;
    logic          press0, press1;
    logic          rel0, rel1;
    logic [CW-1:0] count0, count1;

    int checks;
    int errors;
    int press_seen;
    int release_seen;

    logic [1:0] m_sync  [2];
    logic       m_level [2];
    int         m_run   [2];
    logic       m_press [2];
    logic       m_rel   [2];
    int         m_count [2];

    my_nios_key_debounce #(
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1'b1),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_raw       (key0),
        .count_clr     (clr0),
        .key_level     (level0),
        .press_pulse   (press0),
        .release_pulse (rel0),
        .press_count   (count0)
    );

    my_nios_key_debounce #(
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1'b0),
        .COUNT_WIDTH     (CW)
    ) dut_hi (
        .clk           (clk),
        .reset         (reset),
        .key_raw       (key1),
        .count_clr     (clr1),
        .key_level     (level1),
        .press_pulse   (press1),
        .release_pulse (rel1),
        .press_count   (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the accepted level flips once DB consecutive synchronised samples disagree with it.
    always @(posedge clk or posedge reset) begin
        logic pin [2];
        logic s_old;
        pin[0] = ~key0;
        pin[1] = key1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_sync[i]  = 2'b00;
                m_level[i] = 1'b0;
                m_run[i]   = 0;
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                m_count[i] = 0;
            end else begin
                s_old      = m_sync[i][1];
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                if (s_old != m_level[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        m_level[i] = s_old;
                        m_run[i]   = 0;
                        if (s_old) m_press[i] = 1'b1;
                        else       m_rel[i]   = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if ((i == 0) ? clr0 : clr1) m_count[i] = 0;
                else if (m_press[i] && m_count[i] < CMAX) m_count[i] = m_count[i] + 1;
                m_sync[i] = {m_sync[i][0], pin[i]};
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("lvl0", {7'd0, level0}, {7'd0, m_level[0]});
        check("prs0", {7'd0, press0}, {7'd0, m_press[0]});
        check("rel0", {7'd0, rel0},   {7'd0, m_rel[0]});
        check("cnt0", {4'd0, count0}, 8'(m_count[0]));
        check("lvl1", {7'd0, level1}, {7'd0, m_level[1]});
        check("prs1", {7'd0, press1}, {7'd0, m_press[1]});
        check("rel1", {7'd0, rel1},   {7'd0, m_rel[1]});
        check("cnt1", {4'd0, count1}, 8'(m_count[1]));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (press0) press_seen++;
            if (rel0)   release_seen++;
            check_output();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        press_seen = 0;
        release_seen = 0;
        reset = 1'b1;
        key0 = 1'b1;
        key1 = 1'b0;
        clr0 = 1'b0;
        clr1 = 1'b0;

        tick(3);
        check("rst_level", {7'd0, level0}, 8'd0);
        check("rst_count", {4'd0, count0}, 8'd0);
        reset = 1'b0;
        tick(2);

        $display("[TB] clean press on both builds");
        key0 = 1'b0;
        key1 = 1'b1;
        tick(5);
        check("press_edge5_level0", {7'd0, level0}, 8'd0);
        check("press_edge5_level1", {7'd0, level1}, 8'd0);
        tick(1);
        check("press_edge6_level0", {7'd0, level0}, 8'd1);
        check("press_edge6_pulse0", {7'd0, press0}, 8'd1);
        check("press_edge6_count0", {4'd0, count0}, 8'd1);
        check("press_edge6_level1", {7'd0, level1}, 8'd1);
        tick(1);
        check("press_edge7_pulse0", {7'd0, press0}, 8'd0);
        tick(4);
        key0 = 1'b1;
        key1 = 1'b0;
        tick(8);

        $display("[TB] bounce rejection");
        clr0 = 1'b1;
        tick(1);
        clr0 = 1'b0;
        press_seen = 0;
        release_seen = 0;
        key0 = 1'b0; tick(3);
        key0 = 1'b1; tick(1);
        key0 = 1'b0; tick(3);
        key0 = 1'b1; tick(8);
        check("bounce_level", {7'd0, level0}, 8'd0);
        check("bounce_count", {4'd0, count0}, 8'd0);
        check("bounce_pulses", 8'(press_seen + release_seen), 8'd0);

        $display("[TB] threshold boundary");
        key0 = 1'b0; tick(4);
        key0 = 1'b1; tick(3);
        check("thr_accept_level", {7'd0, level0}, 8'd1);
        key0 = 1'b0; tick(8);
        check("thr_short_release", {7'd0, level0}, 8'd1);
        check("thr_no_release", 8'(release_seen), 8'd0);
        key0 = 1'b1; tick(8);
        check("thr_release_level", {7'd0, level0}, 8'd0);
        check("thr_release_once", 8'(release_seen), 8'd1);

        $display("[TB] saturation and clear");
        clr0 = 1'b1;
        tick(1);
        clr0 = 1'b0;
        for (int k = 0; k < 17; k++) begin
            key0 = 1'b0; tick(7);
            key0 = 1'b1; tick(7);
        end
        check("sat_count", {4'd0, count0}, 8'd15);
        key0 = 1'b0;
        tick(5);
        clr0 = 1'b1;
        tick(1);
        clr0 = 1'b0;
        check("clr_press_pulse", {7'd0, press0}, 8'd1);
        check("clr_press_count", {4'd0, count0}, 8'd0);
        tick(3);
        key0 = 1'b1;
        tick(8);

        $display("[TB] reset mid-debounce");
        key0 = 1'b0;
        tick(3);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_level", {7'd0, level0}, 8'd0);
        check("mid_rst_count", {4'd0, count0}, 8'd0);
        tick(2);
        reset = 1'b0;
        tick(5);
        check("post_rst_edge5", {7'd0, level0}, 8'd0);
        check("post_rst_hi_idle", {7'd0, level1}, 8'd0);
        tick(1);
        check("post_rst_edge6", {7'd0, level0}, 8'd1);
        check("post_rst_count", {4'd0, count0}, 8'd1);
        key0 = 1'b1;
        tick(8);

        $display("[TB] random activity");
        for (int k = 0; k < 300; k++) begin
            key0 = 1'($urandom_range(0, 1));
            key1 = 1'($urandom_range(0, 1));
            clr0 = ($urandom_range(0, 15) == 0);
            clr1 = ($urandom_range(0, 15) == 0);
            tick($urandom_range(1, 7));
        end
        clr0 = 1'b0;
        clr1 = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
